// File: rtl/div_unit_pkg.sv
// Shared definitions for the EX-stage iterative divider: FSM encoding,
// default datapath width and the ALU-control encodings that select a divide.
package div_unit_pkg;

  localparam int DIV_WIDTH = 32;

  // ALU-control encodings the datapath decodes into start / signed_div
  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

  typedef enum logic [2:0] {
    DIV_IDLE = 3'd0,
    DIV_ZERO = 3'd1,
    DIV_CALC = 3'd2,
    DIV_FIX  = 3'd3,
    DIV_DONE = 3'd4
  } div_state_e;

endpackage

// File: rtl/div_unit.sv
// Radix-2 restoring divider producing quotient (LO) and remainder (HI).
// Signed divides run on magnitudes; signs are re-applied in a single FIX cycle.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_div,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic             annul,
  output logic             busy,
  output logic             ready,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             div_by_zero
);

  div_state_e       state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] part_rem;
  logic [WIDTH-1:0] dq;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] dividend_raw;
  logic             neg_q;
  logic             neg_r;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic             accept;

  assign accept = (state == DIV_IDLE) && start && !annul;
  assign abs_a  = (signed_div && opa[WIDTH-1]) ? -opa : opa;
  assign abs_b  = (signed_div && opb[WIDTH-1]) ? -opb : opb;
  // The shifted partial remainder needs WIDTH+1 bits; bit WIDTH of the result is the borrow
  assign trial  = {part_rem, dq[WIDTH-1]} - {1'b0, divisor};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= DIV_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      DIV_IDLE: begin
        if (accept) begin
          state_next = (opb == '0) ? DIV_ZERO : DIV_CALC;
        end else begin
          state_next = DIV_IDLE;
        end
      end
      DIV_ZERO: state_next = annul ? DIV_IDLE : DIV_DONE;
      DIV_CALC: begin
        if (annul) begin
          state_next = DIV_IDLE;
        end else if (cnt == CNT_W'(WIDTH - 1)) begin
          state_next = DIV_FIX;
        end else begin
          state_next = DIV_CALC;
        end
      end
      DIV_FIX:  state_next = annul ? DIV_IDLE : DIV_DONE;
      DIV_DONE: state_next = DIV_IDLE;
      default:  state_next = DIV_IDLE;
    endcase
  end

  // Results are only written on the way into DONE, so an annulled divide leaves them untouched
  always_ff @(posedge clk) begin
    if (rst) begin
      busy         <= 1'b0;
      ready        <= 1'b0;
      quot         <= '0;
      rem          <= '0;
      div_by_zero  <= 1'b0;
      cnt          <= '0;
      part_rem     <= '0;
      dq           <= '0;
      divisor      <= '0;
      dividend_raw <= '0;
      neg_q        <= 1'b0;
      neg_r        <= 1'b0;
    end else begin
      busy  <= (state_next == DIV_ZERO) || (state_next == DIV_CALC) || (state_next == DIV_FIX);
      ready <= (state_next == DIV_DONE);
      case (state)
        DIV_IDLE: begin
          if (accept) begin
            dividend_raw <= opa;
            part_rem     <= '0;
            dq           <= abs_a;
            divisor      <= abs_b;
            neg_q        <= signed_div && (opa[WIDTH-1] != opb[WIDTH-1]);
            neg_r        <= signed_div && opa[WIDTH-1];
            cnt          <= '0;
          end
        end
        DIV_ZERO: begin
          if (!annul) begin
            quot        <= '1;
            rem         <= dividend_raw;
            div_by_zero <= 1'b1;
          end
        end
        DIV_CALC: begin
          if (!annul) begin
            cnt <= cnt + CNT_W'(1);
            if (!trial[WIDTH]) begin
              part_rem <= trial[WIDTH-1:0];
              dq       <= {dq[WIDTH-2:0], 1'b1};
            end else begin
              part_rem <= {part_rem[WIDTH-2:0], dq[WIDTH-1]};
              dq       <= {dq[WIDTH-2:0], 1'b0};
            end
          end
        end
        DIV_FIX: begin
          if (!annul) begin
            quot        <= neg_q ? -dq : dq;
            rem         <= neg_r ? -part_rem : part_rem;
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases, random divides
// against an arithmetic reference, annul / ignored-start / reset sequences.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        signed_div;
  logic [31:0] opa;
  logic [31:0] opb;
  logic        annul;
  logic        busy;
  logic        ready;
  logic [31:0] quot;
  logic [31:0] rem;
  logic        div_by_zero;

  int tests = 0;
  int fails = 0;
  logic [31:0] last_q, last_r;

  div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_div(signed_div),
    .opa(opa), .opb(opb), .annul(annul), .busy(busy), .ready(ready),
    .quot(quot), .rem(rem), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: SV integer division truncates toward zero, remainder takes dividend sign
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                output logic [31:0] q, output logic [31:0] r, output logic z);
    longint sa, sb, lq, lr;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a; z = 1'b1;
    end else if (s) begin
      sa = longint'($signed(a)); sb = longint'($signed(b));
      lq = sa / sb; lr = sa % sb;
      q = lq[31:0]; r = lr[31:0]; z = 1'b0;
    end else begin
      q = a / b; r = a % b; z = 1'b0;
    end
  endfunction

  // Called at a negedge; drives start for one cycle then scrambles inputs
  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s);
    start = 1'b1; opa = a; opb = b; signed_div = s;
    @(negedge clk);
    start = 1'b0; opa = $urandom; opb = $urandom; signed_div = 1'($urandom);
  endtask

  task automatic wait_ready(inout int k);
    while (!ready && k < 100) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic check_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic s);
    logic [31:0] eq, er;
    logic ez;
    int k;
    model(a, b, s, eq, er, ez);
    launch(a, b, s);
    k = 1;
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    wait_ready(k);
    chk({tag, "_lat"}, 64'(k), (b == 32'd0) ? 64'd2 : 64'd34);
    chk({tag, "_quot"}, 64'(quot), 64'(eq));
    chk({tag, "_rem"}, 64'(rem), 64'(er));
    chk({tag, "_dbz"}, 64'(div_by_zero), 64'(ez));
    chk({tag, "_busy_done"}, 64'(busy), 64'd0);
    last_q = eq; last_r = er;
    @(negedge clk);
  endtask

  initial begin
    int k;
    int seen;
    logic [31:0] a, b;
    logic s;
    rst = 1'b1; start = 1'b0; signed_div = 1'b0; opa = '0; opb = '0; annul = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready", 64'(ready), 64'd0);
    chk("rst_quot", 64'(quot), 64'd0);
    chk("rst_rem", 64'(rem), 64'd0);
    chk("rst_dbz", 64'(div_by_zero), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    check_div("divu_7_2", 32'd7, 32'd2, 1'b0);
    check_div("div_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1);
    check_div("div_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1);
    check_div("div_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    check_div("divu_big", 32'hFFFF_FFFF, 32'h10, 1'b0);
    check_div("divu_zero", 32'h1234, 32'h0, 1'b0);
    check_div("div_zero", 32'h8000_0001, 32'h0, 1'b1);

    for (int i = 0; i < 16; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 15);
        2:       b = -($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      s = 1'($urandom);
      check_div("rand", a, b, s);
    end

    // Annul mid-CALC: no ready, prior results kept, restart from T+12
    launch(32'd100, 32'd7, 1'b0);
    k = 1;
    while (k < 10) begin @(negedge clk); k++; end
    annul = 1'b1;
    @(negedge clk); k++;
    annul = 1'b0;
    chk("annul_busy", 64'(busy), 64'd0);
    chk("annul_ready", 64'(ready), 64'd0);
    chk("annul_quot", 64'(quot), 64'(last_q));
    chk("annul_rem", 64'(rem), 64'(last_r));
    @(negedge clk);
    launch(32'd100, 32'd7, 1'b0);
    k = 1;
    wait_ready(k);
    chk("restart_lat", 64'(k), 64'd34);
    chk("restart_quot", 64'(quot), 64'd14);
    chk("restart_rem", 64'(rem), 64'd2);
    @(negedge clk);

    // start during CALC and during DONE is ignored
    launch(32'd1000, 32'd3, 1'b0);
    k = 1;
    while (k < 5) begin @(negedge clk); k++; end
    start = 1'b1; opa = 32'd5; opb = 32'd1;
    @(negedge clk); k++;
    start = 1'b0;
    wait_ready(k);
    chk("ign_lat", 64'(k), 64'd34);
    chk("ign_quot", 64'(quot), 64'd333);
    chk("ign_rem", 64'(rem), 64'd1);
    start = 1'b1; opa = 32'd9; opb = 32'd0;
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    repeat (4) begin
      if (busy || ready) seen++;
      @(negedge clk);
    end
    chk("ign_done_idle", 64'(seen), 64'd0);
    chk("ign_done_quot", 64'(quot), 64'd333);
    chk("ign_done_dbz", 64'(div_by_zero), 64'd0);

    // Synchronous reset mid-operation
    launch(32'hFFFF_0000, 32'd3, 1'b0);
    k = 1;
    while (k < 20) begin @(negedge clk); k++; end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_busy", 64'(busy), 64'd0);
    chk("mrst_ready", 64'(ready), 64'd0);
    chk("mrst_quot", 64'(quot), 64'd0);
    chk("mrst_rem", 64'(rem), 64'd0);
    chk("mrst_dbz", 64'(div_by_zero), 64'd0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy || ready) seen++;
    end
    chk("mrst_quiet", 64'(seen), 64'd0);
    check_div("post_rst", 32'hFFFF_FF00, 32'd16, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative radix-2 restoring divider in the EX stage, downstream of the ALU-control decoder.
- Accepts a DIV/DIVU request, selected when alucontrol equals the EXE_DIV_OP or EXE_DIVU_OP encoding.
- Returns quotient (LO) and remainder (HI) for the HILO write path.
- Asserts busy so the hazard unit stalls the pipeline while a divide is in progress.

Parameters:
- WIDTH, 32, operand/result width in bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  request pulse; sampled only in IDLE
- signed_div  in  1  1 = DIV (signed), 0 = DIVU; sampled with start
- opa  in  WIDTH  dividend (rs), sampled with start
- opb  in  WIDTH  divisor (rt), sampled with start
- annul  in  1  cancel the in-flight divide (flush/exception)
- busy  out  1  high from the cycle after start acceptance until ready
- ready  out  1  one-cycle result-valid pulse
- quot  out  WIDTH  quotient, written to LO
- rem  out  WIDTH  remainder, written to HI
- div_by_zero  out  1  valid with ready; high when opb was 0

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high (rst). rst overrides all other inputs.
- Reset values: state = IDLE; busy, ready, div_by_zero = 0; quot, rem = 0; counter = 0.
- FSM states: IDLE, ZERO, CALC, FIX, DONE.
- IDLE:
  - start=1 and annul=0: latch operands and signed_div.
  - opb==0: go to ZERO. Otherwise load |opa| and |opb| and go to CALC.
  - |x| is taken only when signed_div=1; unsigned operands pass unchanged.
- ZERO, 1 cycle:
  - quot = all-ones, rem = original opa, div_by_zero = 1.
  - Go to DONE.
- CALC, exactly WIDTH cycles, one quotient bit per cycle, MSB first:
  - Shift the {partial remainder, dividend} register left by 1.
  - Trial-subtract the divisor in WIDTH+1 bits.
  - If the result is non-negative, keep it and set the quotient bit to 1; otherwise restore and set the bit to 0.
  - Go to FIX when counter == WIDTH-1.
- FIX, 1 cycle:
  - Signed mode: negate the quotient if the operand signs differ; negate the remainder if the dividend is negative.
  - All arithmetic is modulo 2^WIDTH.
  - Consequence: 0x80000000 / 0xFFFFFFFF (signed) gives quot = 0x80000000, rem = 0.
- DONE, 1 cycle:
  - ready = 1; quot, rem and div_by_zero are valid; go to IDLE.
  - quot, rem and div_by_zero hold their values until the next DONE.
- busy is 1 in ZERO, CALC and FIX; it is 0 in IDLE and DONE.
- Latency, start accepted at cycle T:
  - Normal divide: ready at T+WIDTH+2 (T+34 for WIDTH=32).
  - Divide by zero: ready at T+2.
- Handshake and boundary cases:
  - start outside IDLE is ignored; no queueing.
  - start and annul in the same IDLE cycle: annul wins, nothing is accepted.
  - annul in ZERO, CALC or FIX: go to IDLE next cycle; no ready pulse; quot and rem keep their previous values; busy drops the next cycle.
  - annul in DONE: no effect; the ready pulse still fires. Discarding it is the pipeline's job.
  - start in DONE is ignored; a new start is accepted in IDLE, the cycle after ready at the earliest.
  - rst mid-operation: IDLE next cycle, all outputs at reset values.
  - Operands are registered at acceptance; later input changes do not affect the result.

Decomposition:
- defines.vh (shared):
  - FSM state encodings DIV_IDLE, DIV_ZERO, DIV_CALC, DIV_FIX, DIV_DONE (3 bits).
  - DIV_WIDTH constant.
  - The existing EXE_DIV_OP / EXE_DIVU_OP encodings, used by the datapath to form start and signed_div.
- No sub-module required. Sign handling (abs/negate) is inline; WIDTH+1-bit trial subtract is inline.

Test Plan:
- DIVU 7 / 2, start at T -> ready at T+34; quot = 0x00000003, rem = 0x00000001, div_by_zero = 0.
- DIV 0xFFFFFFF9 (-7) / 2 -> quot = 0xFFFFFFFD, rem = 0xFFFFFFFF; then DIV 7 / 0xFFFFFFFE -> quot = 0xFFFFFFFD, rem = 0x00000001.
- DIV 0x80000000 / 0xFFFFFFFF -> quot = 0x80000000, rem = 0; DIVU 0xFFFFFFFF / 0x10 -> quot = 0x0FFFFFFF, rem = 0xF.
- DIVU 0x1234 / 0 at T -> busy at T+1, ready at T+2; quot = 0xFFFFFFFF, rem = 0x00001234, div_by_zero = 1.
- DIVU 100 / 7, annul at T+10 -> busy = 0 at T+11, no ready ever, quot/rem keep prior values. start again at T+12 -> ready at T+46 with quot = 14, rem = 2.
- start re-pulsed with new operands at T+5 and again in the DONE cycle -> both ignored, first result unchanged. rst at T+20 -> IDLE and all outputs 0 at T+21.
